// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the ADC sample FIFO: pre-trigger ring, post-trigger window, then drain.
// Optional input decimation is enabled by defining ADC_CAPTURE_DECIM_EN.
module adc_capture_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int CNT_WIDTH    = 10,
  parameter int PRE_SAMPLES  = 64,
  parameter int POST_SAMPLES = 384
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trigger,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic [3:0]            decim,
  output logic                  fifo_we,
  output logic [DATA_WIDTH-1:0] fifo_d,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  pre_count
);

  // Stream handshake: a drain word transfers on every clk edge where out_valid && out_ready.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_POST,
    S_DRAIN,
    S_DONE,
    S_FLUSH
  } state_t;

  localparam logic [CNT_WIDTH-1:0] PRE_LIM   = CNT_WIDTH'(PRE_SAMPLES);
  localparam logic [CNT_WIDTH-1:0] POST_LAST = CNT_WIDTH'(POST_SAMPLES - 1);

  state_t                  state, state_next;
  logic [CNT_WIDTH-1:0]    occ, post_cnt, pre_q;
  logic [CNT_WIDTH-1:0]    occ_after;
  logic                    we_q, re_q;
  logic [DATA_WIDTH-1:0]   d_q;
  logic                    busy_q, done_q, ovf_q;
  logic                    accept;
  logic                    wr_en, ring_pop, post_inc, drop, latch_pre, arm_go, occ_inc;

`ifdef ADC_CAPTURE_DECIM_EN
  logic [3:0] dec_cnt;

  assign accept = adc_valid && (dec_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_cnt <= 4'd0;
    end else if (arm_go || latch_pre) begin
      dec_cnt <= 4'd0;
    end else if (adc_valid && (state == S_ARMED || state == S_POST)) begin
      dec_cnt <= (dec_cnt == decim) ? 4'd0 : dec_cnt + 4'd1;
    end
  end
`else
  logic unused_decim;

  assign accept       = adc_valid;
  assign unused_decim = ^decim;
`endif

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    ring_pop   = 1'b0;
    post_inc   = 1'b0;
    drop       = 1'b0;
    latch_pre  = 1'b0;
    arm_go     = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) begin
          state_next = S_ARMED;
          arm_go     = 1'b1;
        end
      end
      S_DONE: begin
        if (abort) begin
          state_next = S_FLUSH;
        end else if (arm) begin
          state_next = S_ARMED;
          arm_go     = 1'b1;
        end
      end
      S_ARMED: begin
        if (abort) begin
          state_next = S_FLUSH;
        end else begin
          if (accept) begin
            wr_en    = 1'b1;
            ring_pop = (occ == PRE_LIM);
          end
          if (trigger) begin
            state_next = S_POST;
            latch_pre  = 1'b1;
          end
        end
      end
      S_POST: begin
        if (abort) begin
          state_next = S_FLUSH;
        end else if (accept) begin
          post_inc = 1'b1;
          if (fifo_full) drop = 1'b1;
          else           wr_en = 1'b1;
          if (post_cnt == POST_LAST) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_next = S_FLUSH;
        end else if (fifo_empty && !we_q) begin
          state_next = S_DONE;
        end
      end
      S_FLUSH: begin
        // A write issued just before the abort must land and be popped before leaving.
        if (fifo_empty && !we_q) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign occ_inc   = (state == S_ARMED) && wr_en && !ring_pop;
  assign occ_after = occ + {{(CNT_WIDTH-1){1'b0}}, occ_inc};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      occ      <= '0;
      post_cnt <= '0;
      pre_q    <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      d_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state  <= state_next;
      we_q   <= wr_en;
      re_q   <= ring_pop;
      busy_q <= !(state_next == S_IDLE || state_next == S_DONE);
      done_q <= (state_next == S_DONE);
      if (wr_en) d_q <= adc_data;
      if (arm_go) begin
        occ      <= '0;
        post_cnt <= '0;
        pre_q    <= '0;
        ovf_q    <= 1'b0;
      end else begin
        occ <= occ_after;
        if (latch_pre) pre_q <= occ_after;
        if (post_inc)  post_cnt <= post_cnt + 1'b1;
        // Also catch a registered write that meets a full FIFO one cycle later.
        if (drop || (we_q && fifo_full)) ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    case (state)
      S_DRAIN: fifo_re = out_valid && out_ready;
      S_FLUSH: fifo_re = !fifo_empty;
      default: fifo_re = re_q && !fifo_empty;
    endcase
  end

  assign fifo_we   = we_q && !fifo_full;
  assign fifo_d    = d_q;
  assign out_valid = (state == S_DRAIN) && !fifo_empty;
  assign out_data  = (state == S_DRAIN) ? fifo_q : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign pre_count = pre_q;

endmodule
